// File: rtl/dnn_argmax_fix.sv
// Sequential argmax over the inference engine's class scores, with a label check
// and saturating total/correct counters for accuracy measurement.
module dnn_argmax_fix #(
  parameter int unsigned DATA_WIDTH  = 13,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned IDX_WIDTH   = 4,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   clear,
  input  logic                                   in_valid,
  input  logic [NUM_CLASSES-1:0][DATA_WIDTH-1:0] in_data,
  input  logic [IDX_WIDTH-1:0]                   in_label,
  output logic                                   busy,
  output logic                                   out_valid,
  output logic [IDX_WIDTH-1:0]                   out_digit,
  output logic signed [DATA_WIDTH-1:0]           out_max,
  output logic                                   out_correct,
  output logic [CNT_WIDTH-1:0]                   total_cnt,
  output logic [CNT_WIDTH-1:0]                   correct_cnt
);

  localparam logic [IDX_WIDTH-1:0] LastPtr = IDX_WIDTH'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {StIdle, StScan, StReport} state_t;

  state_t                       state_q;
  logic                         in_valid_q;
  logic signed [DATA_WIDTH-1:0] score_q [NUM_CLASSES];
  logic [IDX_WIDTH-1:0]         label_q;
  logic signed [DATA_WIDTH-1:0] max_q;
  logic [IDX_WIDTH-1:0]         idx_q;
  logic [IDX_WIDTH-1:0]         ptr_q;

  logic signed [DATA_WIDTH-1:0] cand;
  logic                         cand_gt;
  logic                         match;

  // Strict compare so ties keep the lowest index.
  always_comb begin
    cand    = score_q[ptr_q];
    cand_gt = cand > max_q;
    match   = (idx_q == label_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      // History starts high so a capture needs a fresh low-to-high after reset.
      in_valid_q  <= 1'b1;
      for (int i = 0; i < int'(NUM_CLASSES); i++) score_q[i] <= '0;
      label_q     <= '0;
      max_q       <= '0;
      idx_q       <= '0;
      ptr_q       <= '0;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      out_digit   <= '0;
      out_max     <= '0;
      out_correct <= 1'b0;
      total_cnt   <= '0;
      correct_cnt <= '0;
    end else begin
      in_valid_q <= in_valid;
      out_valid  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid && !in_valid_q) begin
            for (int i = 0; i < int'(NUM_CLASSES); i++) score_q[i] <= in_data[i];
            label_q <= in_label;
            max_q   <= in_data[0];
            idx_q   <= '0;
            ptr_q   <= IDX_WIDTH'(1);
            busy    <= 1'b1;
            state_q <= StScan;
          end
        end
        StScan: begin
          if (cand_gt) begin
            max_q <= cand;
            idx_q <= ptr_q;
          end
          ptr_q <= ptr_q + IDX_WIDTH'(1);
          if (ptr_q == LastPtr) state_q <= StReport;
        end
        StReport: begin
          out_valid   <= 1'b1;
          out_digit   <= idx_q;
          out_max     <= max_q;
          out_correct <= match;
          if (total_cnt != '1) total_cnt <= total_cnt + CNT_WIDTH'(1);
          if (match && (correct_cnt != '1)) correct_cnt <= correct_cnt + CNT_WIDTH'(1);
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      // Placed last so a clear in the report cycle overrides that cycle's count.
      if (clear) begin
        total_cnt   <= '0;
        correct_cnt <= '0;
      end
    end
  end

endmodule
